// File: rtl/frame_sum_pipe.sv
// Three-stage registered adder tree over eight byte lanes, followed by a
// per-frame accumulator that publishes a held frame total with a one-cycle strobe.
module frame_sum_pipe #(
    parameter int DW    = 8,
    parameter int BEATS = 32,
    parameter int SW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in0,
    input  logic [DW-1:0] in1,
    input  logic [DW-1:0] in2,
    input  logic [DW-1:0] in3,
    input  logic [DW-1:0] in4,
    input  logic [DW-1:0] in5,
    input  logic [DW-1:0] in6,
    input  logic [DW-1:0] in7,
    output logic [SW-1:0] sum,
    output logic          sum_valid,
    output logic          busy
);

    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    logic [DW-1:0] lane [8];

    logic [DW:0]   s1_d [4];
    logic [DW:0]   s1_q [4];
    logic [DW+1:0] s2_d [2];
    logic [DW+1:0] s2_q [2];
    logic [DW+2:0] s3_d;
    logic [DW+2:0] s3_q;
    logic          v1_q, v2_q, v3_q;

    logic [SW-1:0] acc_d, acc_q;
    logic [SW-1:0] sum_d, sum_q;
    logic          sum_valid_d, sum_valid_q;
    logic [CW-1:0] beat_cnt_d, beat_cnt_q;
    logic [SW-1:0] beat_ext;
    logic [SW-1:0] acc_sum;

    assign lane[0] = in0;
    assign lane[1] = in1;
    assign lane[2] = in2;
    assign lane[3] = in3;
    assign lane[4] = in4;
    assign lane[5] = in5;
    assign lane[6] = in6;
    assign lane[7] = in7;

    // Pair sums only capture on valid beats; the stale value is ignored via v1.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_stage1
            assign s1_d[gi] = in_valid ? ({1'b0, lane[2*gi]} + {1'b0, lane[2*gi+1]})
                                       : s1_q[gi];
        end
        for (gi = 0; gi < 2; gi++) begin : g_stage2
            assign s2_d[gi] = {1'b0, s1_q[2*gi]} + {1'b0, s1_q[2*gi+1]};
        end
    endgenerate

    assign s3_d = {1'b0, s2_q[0]} + {1'b0, s2_q[1]};

    always_comb begin
        beat_ext    = SW'(s3_q);
        acc_sum     = (beat_cnt_q == '0) ? beat_ext : (acc_q + beat_ext);
        acc_d       = acc_q;
        sum_d       = sum_q;
        sum_valid_d = 1'b0;
        beat_cnt_d  = beat_cnt_q;
        if (v3_q) begin
            acc_d = acc_sum;
            if (beat_cnt_q == LAST) begin
                sum_d       = acc_sum;
                sum_valid_d = 1'b1;
                beat_cnt_d  = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) s1_q[i] <= '0;
            for (int i = 0; i < 2; i++) s2_q[i] <= '0;
            s3_q        <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            acc_q       <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            beat_cnt_q  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) s1_q[i] <= s1_d[i];
            for (int i = 0; i < 2; i++) s2_q[i] <= s2_d[i];
            s3_q        <= s3_d;
            v1_q        <= in_valid;
            v2_q        <= v1_q;
            v3_q        <= v2_q;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign sum       = sum_q;
    assign sum_valid = sum_valid_q;
    assign busy      = v1_q | v2_q | v3_q | (beat_cnt_q != '0);

endmodule

// File: tb/tb_frame_sum_pipe.sv
// Directed bench for frame_sum_pipe: a table of whole frames plus hand-written
// sequences for back-to-back frames and reset corner cases.
module tb_frame_sum_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in0, in1, in2, in3, in4, in5, in6, in7;
    logic [15:0] sum;
    logic        sum_valid;
    logic        busy;

    int tests = 0;
    int fails = 0;
    logic [15:0] prev_sum;

    always #5 clk = ~clk;

    frame_sum_pipe #(.DW(8), .BEATS(32), .SW(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .in4(in4), .in5(in5), .in6(in6), .in7(in7),
        .sum(sum), .sum_valid(sum_valid), .busy(busy)
    );

    typedef struct {
        string       name;
        logic [63:0] lanes;
        int          gap;
        logic [15:0] exp_sum;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("[TB] ok   %s: %0d", name, act);
        end
    endtask

    task automatic set_lanes(input logic [63:0] l);
        in0 = l[7:0];   in1 = l[15:8];  in2 = l[23:16]; in3 = l[31:24];
        in4 = l[39:32]; in5 = l[47:40]; in6 = l[55:48]; in7 = l[63:56];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [63:0] l);
        set_lanes(l);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [63:0] l, input int gap,
                             input logic [15:0] exp);
        int lat;
        int pulses;
        logic [15:0] got;
        lat = 99; pulses = 0; got = 'x;
        for (int b = 0; b < 32; b++) begin
            beat(l);
            if (b < 31) for (int g = 0; g < gap; g++) tick();
        end
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 2) check({tag, " sum held before done"}, {16'd0, sum}, {16'd0, prev_sum});
            if (i == 2) check({tag, " busy in flight"}, {31'd0, busy}, 32'd1);
            if (i == 3) check({tag, " busy after done"}, {31'd0, busy}, 32'd0);
            if (sum_valid) begin
                pulses++;
                if (lat == 99) begin lat = i; got = sum; end
            end
        end
        check({tag, " latency"}, lat, 32'd3);
        check({tag, " pulse count"}, pulses, 32'd1);
        check({tag, " sum"}, {16'd0, got}, {16'd0, exp});
        check({tag, " sum still held"}, {16'd0, sum}, {16'd0, exp});
        prev_sum = exp;
    endtask

    localparam logic [63:0] ALL1   = {8{8'd1}};
    localparam logic [63:0] ALL2   = {8{8'd2}};
    localparam logic [63:0] ALL3   = {8{8'd3}};
    localparam logic [63:0] ALL9   = {8{8'd9}};
    localparam logic [63:0] ALL200 = {8{8'd200}};
    localparam logic [63:0] ALLFF  = {8{8'd255}};
    localparam logic [63:0] RAMP   = {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};

    initial begin
        vec_t vecs [5];
        int pulses;
        int busy_seen;
        int first_idx, second_idx;
        logic [15:0] first_sum, second_sum, mid_sum;
        logic [15:0] avg;

        vecs[0] = '{"ones",       ALL1,  0, 16'd256};
        vecs[1] = '{"all255",     ALLFF, 0, 16'd65280};
        vecs[2] = '{"ramp",       RAMP,  0, 16'd896};
        vecs[3] = '{"ramp gap1",  RAMP,  1, 16'd896};
        vecs[4] = '{"twos gap2",  ALL2,  2, 16'd512};

        rst = 1'b1; in_valid = 1'b0; set_lanes('0);
        tick(); tick();
        check("reset sum", {16'd0, sum}, 32'd0);
        check("reset sum_valid", {31'd0, sum_valid}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        prev_sum = 16'd0;
        tick();

        for (int v = 0; v < 5; v++) begin
            run_frame(vecs[v].name, vecs[v].lanes, vecs[v].gap, vecs[v].exp_sum);
            if (v == 1) begin
                avg = (sum + 16'd128) >> 8;
                check("all255 avg", {16'd0, avg}, 32'd255);
            end
            tick();
        end

        // Back-to-back frames: 64 consecutive beats, watched edge by edge.
        pulses = 0; first_idx = -1; second_idx = -1;
        first_sum = '0; second_sum = '0; mid_sum = '0;
        in_valid = 1'b1;
        for (int e = 0; e < 72; e++) begin
            set_lanes((e < 32) ? ALL1 : ALL2);
            in_valid = (e < 64);
            tick();
            if (e == 50) mid_sum = sum;
            if (sum_valid) begin
                pulses++;
                if (first_idx < 0) begin first_idx = e; first_sum = sum; end
                else if (second_idx < 0) begin second_idx = e; second_sum = sum; end
            end
        end
        in_valid = 1'b0;
        check("b2b first edge", first_idx, 32'd34);
        check("b2b first sum", {16'd0, first_sum}, 32'd256);
        check("b2b held between", {16'd0, mid_sum}, 32'd256);
        check("b2b spacing", second_idx - first_idx, 32'd32);
        check("b2b second sum", {16'd0, second_sum}, 32'd512);
        check("b2b pulses", pulses, 32'd2);
        prev_sum = 16'd512;

        // Reset in the middle of a partial frame.
        for (int b = 0; b < 10; b++) beat(ALL9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst sum", {16'd0, sum}, 32'd0);
        check("midrst busy", {31'd0, busy}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (sum_valid) pulses++;
        end
        check("midrst no pulse", pulses, 32'd0);
        prev_sum = 16'd0;
        run_frame("after midrst", ALL3, 0, 16'd768);
        tick();

        // Reset coinciding with a valid beat drops that beat.
        set_lanes(ALL200);
        in_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        check("rst+valid busy", {31'd0, busy}, 32'd0);
        check("rst+valid sum", {16'd0, sum}, 32'd0);
        busy_seen = 0; pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy) busy_seen++;
            if (sum_valid) pulses++;
        end
        check("rst+valid stays idle", busy_seen + pulses, 32'd0);
        prev_sum = 16'd0;
        run_frame("after rst+valid", ALL1, 0, 16'd256);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
